// File: rtl/arm_isa_pkg.sv
// Shared ARM ISA field constants, encoder state and word-assembly helpers.
// The instruction decoder imports the same package.
`timescale 1ns/1ps
package arm_isa_pkg;

  typedef enum logic [1:0] {
    CLS_DP_IMMSH = 2'd0,
    CLS_DP_REGSH = 2'd1,
    CLS_DP_IMM   = 2'd2,
    CLS_MUL      = 2'd3
  } instr_class_e;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  localparam logic [2:0] MUL_MUL   = 3'b000;
  localparam logic [2:0] MUL_MLA   = 3'b001;
  localparam logic [2:0] MUL_RSV2  = 3'b010;
  localparam logic [2:0] MUL_RSV3  = 3'b011;
  localparam logic [2:0] MUL_UMULL = 3'b100;
  localparam logic [2:0] MUL_UMLAL = 3'b101;
  localparam logic [2:0] MUL_SMULL = 3'b110;
  localparam logic [2:0] MUL_SMLAL = 3'b111;

  localparam logic [3:0] MUL_SIG = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_OUT    = 2'd2
  } enc_state_e;

  typedef struct packed {
    instr_class_e cls;
    logic [3:0]   cond;
    logic [3:0]   opcode;
    logic         s_bit;
    logic [3:0]   rn;
    logic [3:0]   rd;
    logic [3:0]   rm;
    logic [3:0]   rs;
    logic [1:0]   shift_type;
    logic [4:0]   shift_imm;
    logic [31:0]  imm_value;
    logic [2:0]   mul_op;
  } enc_req_t;

  function automatic logic mul_op_reserved(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

  // TST/TEQ/CMP/CMN always set flags and have no destination; MOV/MVN have no Rn.
  function automatic logic [31:0] encode_dp(input enc_req_t q, input logic [3:0] rot,
                                            input logic [7:0] imm8);
    logic [3:0]  rn_f;
    logic [3:0]  rd_f;
    logic        s_f;
    logic [11:0] op2;
    rn_f = q.rn;
    rd_f = q.rd;
    s_f  = q.s_bit;
    if (q.opcode[3:2] == 2'b10) begin
      s_f  = 1'b1;
      rd_f = '0;
    end
    if (q.opcode == OP_MOV || q.opcode == OP_MVN) rn_f = '0;
    case (q.cls)
      CLS_DP_REGSH: op2 = {q.rs, 1'b0, q.shift_type, 1'b1, q.rm};
      CLS_DP_IMM:   op2 = {rot, imm8};
      default:      op2 = {q.shift_imm, q.shift_type, 1'b0, q.rm};
    endcase
    return {q.cond, 2'b00, (q.cls == CLS_DP_IMM), q.opcode, s_f, rn_f, rd_f, op2};
  endfunction

  function automatic logic [31:0] encode_mul(input enc_req_t q);
    return {q.cond, 4'b0000, q.mul_op, q.s_bit, q.rd, q.rn, q.rs, MUL_SIG, q.rm};
  endfunction

endpackage

// File: rtl/instr_encoder_imm_rot_check.sv
// Tests one rotation candidate: does value ROL 2r fit in eight bits?
`timescale 1ns/1ps
module imm_rot_check (
  input  logic [31:0] value,
  input  logic [3:0]  r,
  output logic        match,
  output logic [7:0]  imm8
);

  logic [63:0] dbl;
  logic [31:0] v;

  // Rotating the doubled word avoids a 32-bit shift corner at r=0.
  always_comb begin
    dbl   = {value, value} << {r, 1'b0};
    v     = dbl[63:32];
    match = (v[31:8] == '0);
    imm8  = v[7:0];
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes DP/multiply fields into a 32-bit ARM word; immediates are fitted to
// imm8/rotate by stepping one rotation candidate per cycle.
`timescale 1ns/1ps
module instr_encoder
  import arm_isa_pkg::*;
#(
  parameter int unsigned SEARCH_STEPS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_class,
  input  logic [3:0]  cond,
  input  logic [3:0]  opcode,
  input  logic        s_bit,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [3:0]  rm,
  input  logic [3:0]  rs,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_imm,
  input  logic [31:0] imm_value,
  input  logic [2:0]  mul_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_error
);

  localparam logic [3:0] R_LAST = 4'(SEARCH_STEPS - 1);

  enc_state_e  state_q;
  enc_req_t    req_d;
  enc_req_t    req_q;
  logic [3:0]  r_q;
  logic        out_valid_q;
  logic        out_error_q;
  logic [31:0] out_instr_q;
  logic        rot_match;
  logic [7:0]  rot_imm8;

  always_comb begin
    req_d            = '0;
    req_d.cls        = instr_class_e'(in_class);
    req_d.cond       = cond;
    req_d.opcode     = opcode;
    req_d.s_bit      = s_bit;
    req_d.rn         = rn;
    req_d.rd         = rd;
    req_d.rm         = rm;
    req_d.rs         = rs;
    req_d.shift_type = shift_type;
    req_d.shift_imm  = shift_imm;
    req_d.imm_value  = imm_value;
    req_d.mul_op     = mul_op;
  end

  imm_rot_check u_rot (
    .value (req_q.imm_value),
    .r     (r_q),
    .match (rot_match),
    .imm8  (rot_imm8)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      out_error_q <= 1'b0;
      out_instr_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            req_q <= req_d;
            r_q   <= '0;
            if (req_d.cls == CLS_DP_IMM) begin
              state_q <= ST_SEARCH;
            end else begin
              state_q     <= ST_OUT;
              out_valid_q <= 1'b1;
              if (req_d.cls == CLS_MUL && mul_op_reserved(req_d.mul_op)) begin
                out_error_q <= 1'b1;
                out_instr_q <= '0;
              end else begin
                out_error_q <= 1'b0;
                out_instr_q <= (req_d.cls == CLS_MUL) ? encode_mul(req_d)
                                                      : encode_dp(req_d, '0, '0);
              end
            end
          end
        end
        ST_SEARCH: begin
          if (rot_match) begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
            out_error_q <= 1'b0;
            out_instr_q <= encode_dp(req_q, r_q, rot_imm8);
          end else if (r_q == R_LAST) begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
            out_error_q <= 1'b1;
            out_instr_q <= '0;
          end else begin
            r_q <= r_q + 4'd1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_error = out_error_q;
  assign out_instr = out_instr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, backpressure/reset sequences,
// and randomized requests against an arithmetic reference model.
`timescale 1ns/1ps
module tb_instr_encoder;

  typedef struct {
    bit [1:0]  cls;
    bit [3:0]  cond;
    bit [3:0]  op;
    bit        s;
    bit [3:0]  rn, rd, rm, rs;
    bit [1:0]  st;
    bit [4:0]  shimm;
    bit [31:0] imm;
    bit [2:0]  mop;
  } req_t;

  typedef struct {
    req_t      req;
    bit [31:0] exp_w;
    bit        exp_e;
    int        exp_lat;
    string     name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_class;
  logic [3:0]  cond, opcode, rn, rd, rm, rs;
  logic        s_bit;
  logic [1:0]  shift_type;
  logic [4:0]  shift_imm;
  logic [31:0] imm_value;
  logic [2:0]  mul_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encoder #(.SEARCH_STEPS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_class   (in_class),
    .cond       (cond),
    .opcode     (opcode),
    .s_bit      (s_bit),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm),
    .rs         (rs),
    .shift_type (shift_type),
    .shift_imm  (shift_imm),
    .imm_value  (imm_value),
    .mul_op     (mul_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_error  (out_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic req_t mkreq(bit [1:0] cls, bit [3:0] cnd, bit [3:0] op, bit s,
                                 bit [3:0] n, bit [3:0] d, bit [3:0] m, bit [3:0] sr,
                                 bit [1:0] st, bit [4:0] shimm, bit [31:0] imm, bit [2:0] mop);
    req_t q;
    q.cls = cls; q.cond = cnd; q.op = op; q.s = s; q.rn = n; q.rd = d; q.rm = m;
    q.rs = sr; q.st = st; q.shimm = shimm; q.imm = imm; q.mop = mop;
    return q;
  endfunction

  // Reference: field placement by weighted sums, rotation search by plain rotate.
  task automatic ref_model(input req_t q, output bit [31:0] w, output bit e, output int lat);
    int unsigned s, n, d, op2;
    bit [63:0] t;
    bit [31:0] v;
    bit found;
    w = 0; e = 0; lat = 1; op2 = 0; found = 0;
    if (q.cls == 2'd3) begin
      if (q.mop == 3'd2 || q.mop == 3'd3) begin
        e = 1;
      end else begin
        w = q.cond * 32'h1000_0000 + q.mop * 32'h20_0000 + q.s * 32'h10_0000
          + q.rd * 32'h1_0000 + q.rn * 32'h1000 + q.rs * 32'h100 + 9 * 16 + q.rm;
      end
    end else begin
      s = q.s; n = q.rn; d = q.rd;
      if (q.op >= 8 && q.op <= 11) begin s = 1; d = 0; end
      if (q.op == 13 || q.op == 15) n = 0;
      if (q.cls == 2'd0) op2 = q.shimm * 128 + q.st * 32 + q.rm;
      else if (q.cls == 2'd1) op2 = q.rs * 256 + q.st * 32 + 16 + q.rm;
      else begin
        for (int r = 0; r < 16 && !found; r++) begin
          t = {32'b0, q.imm} << (2 * r);
          v = t[31:0] | t[63:32];
          if (v < 256) begin
            found = 1;
            op2 = r * 256 + v;
            lat = 2 + r;
          end
        end
        if (!found) begin
          e = 1;
          lat = 17;
        end
      end
      if (!e)
        w = q.cond * 32'h1000_0000 + (q.cls == 2'd2 ? 32'h200_0000 : 0) + q.op * 32'h20_0000
          + s * 32'h10_0000 + n * 32'h1_0000 + d * 32'h1000 + op2;
    end
  endtask

  task automatic drive_fields(input req_t q);
    in_class = q.cls; cond = q.cond; opcode = q.op; s_bit = q.s; rn = q.rn; rd = q.rd;
    rm = q.rm; rs = q.rs; shift_type = q.st; shift_imm = q.shimm; imm_value = q.imm;
    mul_op = q.mop;
  endtask

  function automatic req_t rand_req();
    req_t q;
    bit [63:0] t;
    int unsigned sh;
    q = mkreq(2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
              4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom), 5'($urandom),
              $urandom, 3'($urandom));
    if ($urandom_range(0, 3) != 0) begin
      sh = 2 * $urandom_range(0, 15);
      t = {24'b0, 8'($urandom), 32'b0} >> sh;
      q.imm = t[63:32] | t[31:0];
    end
    return q;
  endfunction

  task automatic run_req(input req_t q, input bit [31:0] ew, input bit ee, input int el,
                         input int hold, input string tag);
    int k;
    logic [31:0] held;
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    drive_fields(q);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive_fields(rand_req());
    in_valid = 1'($urandom);
    k = 1;
    @(negedge clk);
    check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(el));
    check({tag, " instr"}, out_instr, ew);
    check({tag, " error"}, 32'(out_error), 32'(ee));
    if (!out_valid) begin
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      return;
    end
    held = out_instr;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, " hold instr"}, out_instr, held);
      check({tag, " hold valid/ready"}, {30'b0, out_valid, in_ready}, 32'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " release"}, {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  vec_t vecs[$];

  initial begin
    bit [31:0] w;
    bit e;
    int lat, seen;
    req_t q;

    vecs.push_back('{mkreq(0, 4'hE, 4'h4, 0, 2, 1, 3, 0, 0, 0, 0, 0), 32'hE0821003, 0, 1, "add_reg"});
    vecs.push_back('{mkreq(1, 4'hE, 4'h4, 0, 1, 0, 2, 3, 0, 0, 0, 0), 32'hE0810312, 0, 1, "add_regsh"});
    vecs.push_back('{mkreq(2, 4'hE, 4'hD, 0, 7, 0, 0, 0, 0, 0, 32'hFF000000, 0), 32'hE3A004FF, 0, 6, "mov_imm"});
    vecs.push_back('{mkreq(2, 4'hE, 4'hA, 0, 1, 5, 0, 0, 0, 0, 32'h1, 0), 32'hE3510001, 0, 2, "cmp_imm"});
    vecs.push_back('{mkreq(2, 4'hE, 4'h4, 0, 1, 2, 0, 0, 0, 0, 32'h101, 0), 32'h0, 1, 17, "imm_err"});
    vecs.push_back('{mkreq(3, 4'hE, 4'h0, 0, 0, 4, 5, 6, 0, 0, 0, 0), 32'hE0040695, 0, 1, "mul"});
    vecs.push_back('{mkreq(3, 4'hE, 4'h0, 0, 0, 4, 5, 6, 0, 0, 0, 2), 32'h0, 1, 1, "mul_rsv"});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive_fields(mkreq(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {29'b0, out_valid, out_error, in_ready}, 32'b001);
    check("reset instr", out_instr, 32'h0);
    rst = 1'b0;

    foreach (vecs[i])
      run_req(vecs[i].req, vecs[i].exp_w, vecs[i].exp_e, vecs[i].exp_lat, 0, vecs[i].name);

    run_req(vecs[0].req, vecs[0].exp_w, 0, 1, 5, "backpressure");

    // Reset while searching at r=3: nothing may be emitted.
    @(negedge clk);
    drive_fields(vecs[4].req);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst in search", {30'b0, out_valid, in_ready}, 32'b01);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no word after rst", 32'(seen), 32'd0);

    // Reset while holding a word with out_ready low.
    @(negedge clk);
    drive_fields(vecs[5].req);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst in out", {29'b0, out_valid, out_error, in_ready}, 32'b001);
    check("rst in out instr", out_instr, 32'h0);

    for (int i = 0; i < 150; i++) begin
      q = rand_req();
      ref_model(q, w, e, lat);
      run_req(q, w, e, lat, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
